// File: rtl/si570_pkg.sv
// Shared constants, FSM state type and image helpers for the Si-570 programmer.
// Readback is compiled in only when SI570_READBACK_EN is defined.
package si570_pkg;

    localparam logic [7:0] REG_HSDIV  = 8'd7;
    localparam logic [7:0] REG_CTRL   = 8'd135;
    localparam logic [7:0] REG_FREEZE = 8'd137;
    localparam logic [7:0] FREEZE_DCO = 8'h10;
    localparam logic [7:0] NEWFREQ    = 8'h40;

    localparam logic [2:0] FC_OK    = 3'd0;
    localparam logic [2:0] FC_NACK  = 3'd1;
    localparam logic [2:0] FC_TMO   = 3'd2;
    localparam logic [2:0] FC_POLL  = 3'd3;
    localparam logic [2:0] FC_RBACK = 3'd4;

    // Step index: 0 freeze, 1..6 regs 7..12, 7 unfreeze, 8 NewFreq, 9 poll, 10..15 readback
    localparam logic [3:0] STEP_FREEZE   = 4'd0;
    localparam logic [3:0] STEP_UNFREEZE = 4'd7;
    localparam logic [3:0] STEP_NEWFREQ  = 4'd8;
    localparam logic [3:0] STEP_POLL     = 4'd9;
    localparam logic [3:0] STEP_RB_FIRST = 4'd10;
    localparam logic [3:0] STEP_RB_LAST  = 4'd15;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_FINISH} state_e;

    // The 48-bit image is b7..b12 back to back, which is exactly {hsdiv, n1, rfreq}
    function automatic logic [47:0] build_image(input logic [2:0] hsdiv, input logic [6:0] n1,
                                                input logic [37:0] rfreq);
        return {hsdiv, n1, rfreq};
    endfunction

    function automatic logic [7:0] image_byte(input logic [47:0] img, input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = img[47:40];
            3'd1:    b = img[39:32];
            3'd2:    b = img[31:24];
            3'd3:    b = img[23:16];
            3'd4:    b = img[15:8];
            3'd5:    b = img[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/si570_programmer_if.sv
// Byte-level transaction handshake between the Si-570 programmer and the I2C master.
interface si570_programmer_if;
    logic       i2c_bus_sel;
    logic       i2c_start;
    logic       i2c_rnw;
    logic [6:0] i2c_dev;
    logic [7:0] i2c_reg;
    logic [7:0] i2c_wdata;
    logic       i2c_done;
    logic       i2c_nack;
    logic [7:0] i2c_rdata;

    modport master (
        output i2c_bus_sel, i2c_start, i2c_rnw, i2c_dev, i2c_reg, i2c_wdata,
        input  i2c_done, i2c_nack, i2c_rdata
    );

    modport slave (
        input  i2c_bus_sel, i2c_start, i2c_rnw, i2c_dev, i2c_reg, i2c_wdata,
        output i2c_done, i2c_nack, i2c_rdata
    );
endinterface

// File: rtl/si570_xact_timer.sv
// Loadable down-counter; expired_o is high while the count sits at zero.
module si570_xact_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             expired_o
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             expired_q;

    // Next count: load wins, otherwise count down and stick at zero
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count and expired flag registers
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= '0;
            expired_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            expired_q <= (count_d == '0);
        end
    end

    assign expired_o = expired_q;

endmodule

// File: rtl/si570_programmer.sv
// Programs one Si-570: freeze DCO, write regs 7..12, unfreeze, set NewFreq, poll it clear.
// Defining SI570_READBACK_EN adds a verify read of regs 7..12 after the poll.
module si570_programmer
    import si570_pkg::*;
#(
    parameter int         CLOCK_FREQ  = 200000000,
    parameter logic [6:0] SI570_ADDR  = 7'h5D,
    parameter int         XACT_TMO_US = 1000,
    parameter int         POLL_LIMIT  = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      pgm_start,
    input  logic                      which_si570,
    input  logic [2:0]                cfg0_hsdiv,
    input  logic [6:0]                cfg0_n1,
    input  logic [37:0]               cfg0_rfreq,
    input  logic [2:0]                cfg1_hsdiv,
    input  logic [6:0]                cfg1_n1,
    input  logic [37:0]               cfg1_rfreq,
    output logic                      pgm_done,
    output logic                      pgm_fault,
    output logic [2:0]                fault_code,
    si570_programmer_if.master        i2c
);

    localparam int TMO_CYCLES = CLOCK_FREQ / 1000000 * XACT_TMO_US;
    localparam int TW         = $clog2(TMO_CYCLES);
    // Loaded in ISSUE so that an unanswered transaction finishes exactly TMO_CYCLES after ISSUE
    localparam logic [TW-1:0] TMO_LOAD = TW'(TMO_CYCLES - 2);
    localparam int PW = $clog2(POLL_LIMIT + 1);
    localparam logic [PW-1:0] POLL_MAX = PW'(POLL_LIMIT);

    state_e        state_q, state_d;
    logic [3:0]    step_q, step_d;
    logic [PW-1:0] poll_q, poll_d;
    logic [47:0]   img_q, img_d;
    logic [2:0]    fault_q, fault_d;
    logic          sel_q, sel_d, done_q, done_d, pfault_q, pfault_d;
    logic          start_q, start_d, rnw_q, rnw_d;
    logic [6:0]    dev_q, dev_d;
    logic [7:0]    reg_q, reg_d, wdata_q, wdata_d;
    logic          tmr_load_s, tmr_expired_s;

    function automatic logic [2:0] step_idx(input logic [3:0] step);
        return (step < STEP_UNFREEZE) ? 3'(step - 4'd1) : 3'(step - STEP_RB_FIRST);
    endfunction

    function automatic logic [7:0] step_reg(input logic [3:0] step);
        logic [7:0] r;
        case (step)
            STEP_FREEZE, STEP_UNFREEZE: r = REG_FREEZE;
            STEP_NEWFREQ, STEP_POLL:    r = REG_CTRL;
            default:                    r = REG_HSDIV + {5'd0, step_idx(step)};
        endcase
        return r;
    endfunction

    function automatic logic [7:0] step_wdata(input logic [3:0] step, input logic [47:0] img);
        logic [7:0] w;
        case (step)
            STEP_FREEZE:   w = FREEZE_DCO;
            STEP_UNFREEZE: w = 8'h00;
            STEP_NEWFREQ:  w = NEWFREQ;
            default:       w = (step < STEP_UNFREEZE) ? image_byte(img, step_idx(step)) : 8'h00;
        endcase
        return w;
    endfunction

    si570_xact_timer #(.WIDTH(TW)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (tmr_load_s),
        .load_val_i (TMO_LOAD),
        .expired_o  (tmr_expired_s)
    );

    // Sequencer next state plus next values of every registered output
    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        poll_d     = poll_q;
        img_d      = img_q;
        fault_d    = fault_q;
        sel_d      = sel_q;
        tmr_load_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pgm_start) begin
                    sel_d   = which_si570;
                    img_d   = which_si570 ? build_image(cfg1_hsdiv, cfg1_n1, cfg1_rfreq)
                                          : build_image(cfg0_hsdiv, cfg0_n1, cfg0_rfreq);
                    fault_d = FC_OK;
                    step_d  = STEP_FREEZE;
                    poll_d  = '0;
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                tmr_load_s = 1'b1;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                // A done that coincides with expiry still counts as success
                if (i2c.i2c_done) begin
                    if (i2c.i2c_nack) begin
                        fault_d = FC_NACK;
                        state_d = ST_FINISH;
                    end else if (step_q == STEP_POLL) begin
                        if (i2c.i2c_rdata[6]) begin
                            poll_d = poll_q + PW'(1);
                            if (poll_d == POLL_MAX) begin
                                fault_d = FC_POLL;
                                state_d = ST_FINISH;
                            end else begin
                                state_d = ST_ISSUE;
                            end
                        end else begin
`ifdef SI570_READBACK_EN
                            step_d  = STEP_RB_FIRST;
                            state_d = ST_ISSUE;
`else
                            state_d = ST_FINISH;
`endif
                        end
`ifdef SI570_READBACK_EN
                    end else if (step_q >= STEP_RB_FIRST) begin
                        if (i2c.i2c_rdata != image_byte(img_q, step_idx(step_q))) begin
                            fault_d = FC_RBACK;
                            state_d = ST_FINISH;
                        end else if (step_q == STEP_RB_LAST) begin
                            state_d = ST_FINISH;
                        end else begin
                            step_d  = step_q + 4'd1;
                            state_d = ST_ISSUE;
                        end
`endif
                    end else begin
                        step_d  = step_q + 4'd1;
                        state_d = ST_ISSUE;
                    end
                end else if (tmr_expired_s) begin
                    fault_d = FC_TMO;
                    state_d = ST_FINISH;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        start_d  = (state_d == ST_ISSUE);
        done_d   = (state_d == ST_FINISH);
        pfault_d = done_d && (fault_d != FC_OK);
        if (state_d == ST_ISSUE) begin
            rnw_d   = (step_d >= STEP_POLL);
            dev_d   = SI570_ADDR;
            reg_d   = step_reg(step_d);
            wdata_d = step_wdata(step_d, img_d);
        end else begin
            rnw_d   = rnw_q;
            dev_d   = dev_q;
            reg_d   = reg_q;
            wdata_d = wdata_q;
        end
    end

    // State and output registers; reset abandons any transaction in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            step_q   <= 4'd0;
            poll_q   <= '0;
            img_q    <= 48'd0;
            fault_q  <= FC_OK;
            sel_q    <= 1'b0;
            done_q   <= 1'b0;
            pfault_q <= 1'b0;
            start_q  <= 1'b0;
            rnw_q    <= 1'b0;
            dev_q    <= 7'd0;
            reg_q    <= 8'd0;
            wdata_q  <= 8'd0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            poll_q   <= poll_d;
            img_q    <= img_d;
            fault_q  <= fault_d;
            sel_q    <= sel_d;
            done_q   <= done_d;
            pfault_q <= pfault_d;
            start_q  <= start_d;
            rnw_q    <= rnw_d;
            dev_q    <= dev_d;
            reg_q    <= reg_d;
            wdata_q  <= wdata_d;
        end
    end

    assign pgm_done        = done_q;
    assign pgm_fault       = pfault_q;
    assign fault_code      = fault_q;
    assign i2c.i2c_bus_sel = sel_q;
    assign i2c.i2c_start   = start_q;
    assign i2c.i2c_rnw     = rnw_q;
    assign i2c.i2c_dev     = dev_q;
    assign i2c.i2c_reg     = reg_q;
    assign i2c.i2c_wdata   = wdata_q;

endmodule
